config_chain_loader: RTL and testbench

Serial programmer for the configuration-flip-flop chain that drives every `sel`/`selb` pair in the fabric's routing multiplexers and LUTs. It accepts configuration words over a valid/ready stream and shifts them bit-serially into the chain head, one bit per `prog_clk` cycle with a shift-enable strobe. With verification compiled in, it runs a second pass: the host resends the same stream, and the loader compares the chain tail against it bit-for-bit.

---
 rtl/config_chain_pkg.sv | 21 ++
 rtl/config_chain_loader_serializer.sv | 56 +++++
 rtl/config_chain_loader.sv | 156 +++++++++++++++
 tb/tb_config_chain_loader.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/config_chain_pkg.sv
// config_chain_pkg
// Shared types and constants for the configuration-chain loader.
//   state_e     : loader FSM states
//   cnt_width() : width of a counter that has to hold the value len
//   LSB_FIRST   : serial bit order of each stream word
package config_chain_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam bit LSB_FIRST = 1'b1;

  function automatic int cnt_width(input int len);
    return $clog2(len + 1);
  endfunction

endpackage

// File: rtl/config_chain_loader_serializer.sv
// ccff_word_serializer
// Loadable DATA_W-bit shift register with a bit-index down-counter.
// Ports:
//   prog_clk, prog_reset_n : clock, async active-low reset
//   load, load_data        : capture a new word (bit 0 becomes current)
//   advance                : move to the next bit of the word
//   bit_out                : current serial bit
//   last_bit               : current bit is the final bit of the word
module ccff_word_serializer
  import config_chain_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              prog_clk,
  input  logic              prog_reset_n,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              advance,
  output logic              bit_out,
  output logic              last_bit
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [IDX_W-1:0]  bits_left_q, bits_left_d;

  always_comb begin
    shreg_d     = shreg_q;
    bits_left_d = bits_left_q;
    if (load) begin
      shreg_d     = load_data;
      bits_left_d = IDX_LAST;
    end else if (advance) begin
      if (LSB_FIRST) shreg_d = shreg_q >> 1;
      else           shreg_d = shreg_q << 1;
      // Saturate at zero; the owner reloads before using the register again.
      if (bits_left_q != '0) bits_left_d = bits_left_q - IDX_W'(1);
    end
  end

  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      shreg_q     <= '0;
      bits_left_q <= '0;
    end else begin
      shreg_q     <= shreg_d;
      bits_left_q <= bits_left_d;
    end
  end

  assign bit_out  = LSB_FIRST ? shreg_q[0] : shreg_q[DATA_W-1];
  assign last_bit = (bits_left_q == '0);

endmodule

// File: rtl/config_chain_loader.sv
// config_chain_loader
// Serial programmer for the configuration flip-flop chain. Words arrive on a
// valid/ready stream and are shifted LSB first into the chain head, one bit
// per prog_clk with ccff_shift_en. With CONFIG_CHAIN_VERIFY_EN defined a
// second pass rewrites the same stream while comparing ccff_tail to the bit
// being shifted; any difference sets the sticky error flag.
// Ports:
//   prog_clk, prog_reset_n    : clock, async active-low reset
//   start                     : begin programming (ignored while busy)
//   s_data, s_valid, s_ready  : configuration word stream
//   ccff_head, ccff_shift_en  : serial data and shift strobe to the chain
//   ccff_tail                 : chain tail (verify pass only)
//   busy, done, error         : status
//
// state    | meaning
// ---------+--------------------------------------------------
// ST_IDLE  | waiting for start
// ST_FETCH | s_ready high, waiting for the next word
// ST_SHIFT | one chain bit per cycle from the current word
// ST_DONE  | one-cycle completion pulse
module config_chain_loader
  import config_chain_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int CHAIN_LEN = 64,
  parameter int CNT_W     = cnt_width(CHAIN_LEN)
) (
  input  logic              prog_clk,
  input  logic              prog_reset_n,
  input  logic              start,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHAIN_LEN - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             word_bit, word_last, word_load;
  logic             chain_last, final_pass;

  assign word_load  = (state_q == ST_FETCH) && s_valid;
  assign chain_last = (cnt_q == CNT_LAST);

  ccff_word_serializer #(
    .DATA_W(DATA_W)
  ) u_serializer (
    .prog_clk    (prog_clk),
    .prog_reset_n(prog_reset_n),
    .load        (word_load),
    .load_data   (s_data),
    .advance     (state_q == ST_SHIFT),
    .bit_out     (word_bit),
    .last_bit    (word_last)
  );

  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) state_q <= ST_IDLE;
    else               state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_FETCH;
      ST_FETCH: if (s_valid) state_d = ST_SHIFT;
      ST_SHIFT: begin
        // The chain filling up wins over the word running out: leftover
        // bits of the final word are simply dropped.
        if (chain_last)     state_d = final_pass ? ST_DONE : ST_FETCH;
        else if (word_last) state_d = ST_FETCH;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    s_ready       = 1'b0;
    ccff_shift_en = 1'b0;
    ccff_head     = 1'b0;
    busy          = 1'b1;
    done          = 1'b0;
    case (state_q)
      ST_IDLE:  busy = 1'b0;
      ST_FETCH: s_ready = 1'b1;
      ST_SHIFT: begin
        ccff_shift_en = 1'b1;
        ccff_head     = word_bit;
      end
      ST_DONE:  done = 1'b1;
      default:  busy = 1'b0;
    endcase
  end

  // Chain bit counter, restarted at the beginning of every pass.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == ST_IDLE) begin
      cnt_d = '0;
    end else if (state_q == ST_SHIFT) begin
      if (chain_last) cnt_d = '0;
      else            cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) cnt_q <= '0;
    else               cnt_q <= cnt_d;
  end

`ifdef CONFIG_CHAIN_VERIFY_EN
  logic pass_q, pass_d;
  logic error_q, error_d;

  assign final_pass = pass_q;
  assign error      = error_q;

  always_comb begin
    pass_d  = pass_q;
    error_d = error_q;
    if (state_q == ST_IDLE) begin
      pass_d = 1'b0;
      if (start) error_d = 1'b0;
    end else if (state_q == ST_SHIFT) begin
      if (chain_last) pass_d = 1'b1;
      // After pass 1 the tail presents exactly the bit being resent now.
      if (pass_q && (ccff_tail != word_bit)) error_d = 1'b1;
    end
  end

  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      pass_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      pass_q  <= pass_d;
      error_q <= error_d;
    end
  end
`else
  logic unused_tail;

  assign unused_tail = ccff_tail;
  assign final_pass  = 1'b1;
  assign error       = 1'b0;
`endif

endmodule

// File: tb/tb_config_chain_loader.sv
module tb_config_chain_loader;

`ifdef CONFIG_CHAIN_VERIFY_EN
  localparam int PASSES = 2;
`else
  localparam int PASSES = 1;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start   [2];
  logic [7:0] s_data  [2];
  logic       s_valid [2];
  logic       s_ready [2];
  logic       head    [2];
  logic       sh_en   [2];
  logic       tail    [2];
  logic       busy    [2];
  logic       done    [2];
  logic       err     [2];

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural chains: bit 0 is the tail, new bits enter at the top.
  logic [15:0] chain0 = '0;
  logic [9:0]  chain1 = '0;
  bit          stuck5 = 1'b0;

  always @(posedge clk)
    if (sh_en[0]) chain0 <= {head[0], chain0[15:1]} & (stuck5 ? 16'hFFDF : 16'hFFFF);
  always @(posedge clk)
    if (sh_en[1]) chain1 <= {head[1], chain1[9:1]};

  assign tail[0] = chain0[0];
  assign tail[1] = chain1[0];

  config_chain_loader #(.DATA_W(8), .CHAIN_LEN(16)) dut0 (
    .prog_clk(clk), .prog_reset_n(rst_n), .start(start[0]),
    .s_data(s_data[0]), .s_valid(s_valid[0]), .s_ready(s_ready[0]),
    .ccff_head(head[0]), .ccff_shift_en(sh_en[0]), .ccff_tail(tail[0]),
    .busy(busy[0]), .done(done[0]), .error(err[0]));

  config_chain_loader #(.DATA_W(8), .CHAIN_LEN(10)) dut1 (
    .prog_clk(clk), .prog_reset_n(rst_n), .start(start[1]),
    .s_data(s_data[1]), .s_valid(s_valid[1]), .s_ready(s_ready[1]),
    .ccff_head(head[1]), .ccff_shift_en(sh_en[1]), .ccff_tail(tail[1]),
    .busy(busy[1]), .done(done[1]), .error(err[1]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drives one programming run on DUT k and checks every output cycle
  // against the expected bit stream derived from the words.
  task automatic run_stream(input int k, input int len, input logic [7:0] words[$],
                            input int stall_at, input int exp_done, input logic exp_err,
                            input int abort_at, output logic [63:0] seq);
    logic       expb[$];
    logic [7:0] hq[$];
    int wi = 0, si = 0, stall = 0, stall_cycles = 0, done_cyc = -1, ndone = 0, nready = 0;
    bit finished = 0, aborted = 0;
    seq = '0;
    for (int p = 0; p < PASSES; p++) begin
      int n = 0;
      foreach (words[i]) begin
        hq.push_back(words[i]);
        for (int b = 0; b < 8; b++)
          if (n < len) begin
            expb.push_back(words[i][b]);
            n++;
          end
      end
    end
    @(negedge clk);
    for (int cyc = 0; cyc < 300 && !finished; cyc++) begin
      start[k] = (cyc == 0);
      if (cyc == 1) begin
        check("ready_after_start", s_ready[k], 1);
        check("error_cleared_by_start", err[k], 0);
      end
      if (sh_en[k]) begin
        if (si < expb.size()) check("head_bit", head[k], expb[si]);
        else check("shift_count_overrun", si, expb.size() - 1);
        check("ready_during_shift", s_ready[k], 0);
        seq[si[5:0]] = head[k];
        si++;
      end
      if (s_ready[k]) nready++;
      if (s_ready[k] && wi == stall_at && stall_cycles == 0) begin
        stall = 5;
        stall_cycles = 5;
      end
      if (stall > 0) begin
        s_valid[k] = 1'b0;
        check("stall_no_shift", sh_en[k], 0);
        stall--;
      end else if (wi < hq.size()) begin
        s_valid[k] = 1'b1;
        s_data[k]  = hq[wi];
        if (s_ready[k]) wi++;
      end else begin
        s_valid[k] = 1'b0;
      end
      if (done[k]) begin
        ndone++;
        if (done_cyc < 0) done_cyc = cyc;
        check("busy_with_done", busy[k], 1);
      end
      if (done_cyc >= 0 && cyc == done_cyc + 1) begin
        check("busy_after_done", busy[k], 0);
        check("done_width", done[k], 0);
        finished = 1;
      end
      if (abort_at > 0 && si == abort_at && !finished) begin
        #2 rst_n = 1'b0;
        #1;
        check("abort_shift_en", sh_en[k], 0);
        check("abort_busy", busy[k], 0);
        check("abort_s_ready", s_ready[k], 0);
        aborted  = 1;
        finished = 1;
      end
      if (!finished) @(negedge clk);
    end
    s_valid[k] = 1'b0;
    start[k]   = 1'b0;
    if (!aborted) begin
      check("done_cycle", done_cyc, exp_done);
      check("done_pulses", ndone, 1);
      check("shift_total", si, len * PASSES);
      check("words_taken", wi, hq.size());
      check("ready_cycles", nready, hq.size() + stall_cycles);
      check("error_final", err[k], exp_err);
    end
  endtask

  logic [7:0]  wq[$];
  logic [63:0] seq;

  initial begin
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      start[k] = 1'b0; s_valid[k] = 1'b0; s_data[k] = '0;
    end
    #1 rst_n = 1'b0;
    #2;
    for (int k = 0; k < 2; k++) begin
      check("rst_s_ready", s_ready[k], 0);
      check("rst_shift_en", sh_en[k], 0);
      check("rst_head", head[k], 0);
      check("rst_busy", busy[k], 0);
      check("rst_done", done[k], 0);
      check("rst_error", err[k], 0);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // 0xA5, 0x3C into a 16-bit chain: 18 cycles per pass, done on cycle 19.
    wq = {8'hA5, 8'h3C};
    run_stream(0, 16, wq, -1, PASSES * 18 + 1, 1'b0, 0, seq);
    check("seq_a5_3c", seq[15:0], 16'h3CA5);
    check("chain_a5_3c", chain0, 16'h3CA5);

    // 10-bit chain: second word only contributes its two low bits.
    wq = {8'hFF, 8'h03};
    run_stream(1, 10, wq, -1, PASSES * 12 + 1, 1'b0, 0, seq);
    check("seq_ff_03", seq[9:0], 10'h3FF);
    check("chain_ff_03", chain1, 10'h3FF);

    // Five-cycle stall in the bubble between words.
    wq = {8'hA5, 8'h3C};
    run_stream(0, 16, wq, 1, PASSES * 18 + 1 + 5, 1'b0, 0, seq);
    check("seq_stall", seq[15:0], 16'h3CA5);

    wq = {8'h5A, 8'hC3};
    run_stream(0, 16, wq, -1, PASSES * 18 + 1, 1'b0, 0, seq);
    check("seq_5a_c3", seq[15:0], 16'hC35A);
    check("chain_5a_c3", chain0, 16'hC35A);

`ifdef CONFIG_CHAIN_VERIFY_EN
    // Bit 5 of the chain stuck at 0: pass 2 must see the tail disagree.
    stuck5 = 1'b1;
    wq = {8'hFF, 8'hFF};
    run_stream(0, 16, wq, -1, PASSES * 18 + 1, 1'b1, 0, seq);
    check("seq_stuck", seq[15:0], 16'hFFFF);
    repeat (3) @(negedge clk);
    check("error_sticky", err[0], 1);
    stuck5 = 1'b0;
`endif

    // Abort with reset on the seventh shift, then a clean restart.
    wq = {8'hA5, 8'h3C};
    run_stream(0, 16, wq, -1, 0, 1'b0, 7, seq);
    check("abort_seq", seq[6:0], 7'h25);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_abort_busy", busy[0], 0);
    check("post_abort_ready", s_ready[0], 0);
    run_stream(0, 16, wq, -1, PASSES * 18 + 1, 1'b0, 0, seq);
    check("seq_restart", seq[15:0], 16'h3CA5);
    check("chain_restart", chain0, 16'h3CA5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
